// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle lab-CPU control FSM: states, opcodes,
// datapath mux encodings and the bundled control word.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM_LD, S_MEM_ST, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_MV = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3, OP_LD = 4'd4,
    OP_ST = 4'd5, OP_MVHI = 4'd6, OP_J = 4'd8, OP_JZ = 4'd9, OP_JN = 4'd10,
    OP_CALL = 4'd12
  } opcode_t;

  typedef enum logic [2:0] {
    A_PC = 3'd0, A_PC_NEXT = 3'd1, A_REG_TGT = 3'd2, A_RX = 3'd3, A_IMM_TGT = 3'd4
  } addr_sel_t;

  typedef enum logic [1:0] {PC_REG = 2'd0, PC_INC = 2'd1, PC_IMM = 2'd2} pc_sel_t;

  typedef enum logic [2:0] {
    RF_IMM = 3'd0, RF_MVHI = 3'd1, RF_ALU = 3'd2, RF_PC = 3'd3, RF_MEM = 3'd4, RF_RY = 3'd6
  } rf_sel_t;

  typedef struct packed {
    logic      rd;
    logic      wr;
    addr_sel_t addr_sel;
    pc_sel_t   pc_sel;
    logic      pc_ld;
    logic      ir_ld;
    rf_sel_t   rf_sel;
    logic      rf_write;
    logic      rf_addr_w_sel;
    logic      n_ld;
    logic      z_ld;
    logic      alu_b_sel;
    logic      alu_op;
    logic      halted;
  } ctrl_t;

  function automatic logic op_defined(input logic [3:0] opc);
    return opc inside {OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST, OP_MVHI,
                       OP_J, OP_JZ, OP_JN, OP_CALL};
  endfunction

  // Instruction fetch with PC increment; a = A_PC from S_FETCH, A_PC_NEXT when overlapped.
  function automatic ctrl_t f_fetch(input addr_sel_t a);
    ctrl_t c;
    c          = '0;
    c.rd       = 1'b1;
    c.addr_sel = a;
    c.pc_sel   = PC_INC;
    c.pc_ld    = 1'b1;
    c.ir_ld    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t f_jump(input logic imm);
    ctrl_t c;
    c          = '0;
    c.rd       = 1'b1;
    c.addr_sel = imm ? A_IMM_TGT : A_REG_TGT;
    c.pc_sel   = imm ? PC_IMM : PC_REG;
    c.pc_ld    = 1'b1;
    c.ir_ld    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                 r_cnt <= '0;
    else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/cpu_control_ws.sv
// Multicycle control FSM for the 16-bit lab CPU with memory wait-states,
// HALT, illegal-opcode trap and a saturating retired-instruction counter.
module cpu_control_ws
  import cpu_ctrl_pkg::*;
#(
  parameter int         WAIT_EN      = 1,
  parameter int         TRAP_ILLEGAL = 1,
  parameter int         CNT_W        = 16,
  parameter logic [3:0] HALT_OPC     = 4'hF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [4:0]       i_ir,
  input  logic             i_alu_n,
  input  logic             i_alu_z,
  input  logic             i_mem_wait,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic [2:0]       o_mem_addr_sel,
  output logic [1:0]       o_pc_sel,
  output logic             o_pc_ld,
  output logic             o_ir_ld,
  output logic [2:0]       o_rf_sel,
  output logic             o_rf_write,
  output logic             o_rf_addr_w_sel,
  output logic             o_alu_n_ld,
  output logic             o_alu_z_ld,
  output logic             o_alu_b_sel,
  output logic             o_alu_op,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);
  state_t     r_state, w_next;
  ctrl_t      w_ctl, w_out;
  logic [3:0] w_opc;
  logic       w_imm, w_is_halt, w_is_bad, w_trap, w_stall, w_retire;
  logic       r_illegal;

  assign w_opc     = i_ir[3:0];
  assign w_imm     = i_ir[4];
  assign w_is_halt = (w_opc == HALT_OPC);
  assign w_is_bad  = !w_is_halt && !op_defined(w_opc);
  assign w_trap    = (r_state == S_EXEC) && w_is_bad && (TRAP_ILLEGAL != 0);
  assign w_stall   = (WAIT_EN != 0) && (w_ctl.rd || w_ctl.wr) && i_mem_wait;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_FETCH;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_halt || w_trap)     w_next = S_HALT;
        else if (w_opc == OP_LD)     w_next = S_MEM_LD;
        else if (w_opc == OP_ST)     w_next = S_MEM_ST;
      end
      S_MEM_LD, S_MEM_ST: w_next = S_EXEC;
      default:  w_next = S_HALT;
    endcase
    if (w_stall) w_next = r_state;
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH:  w_ctl = f_fetch(A_PC);
      S_MEM_LD: begin
        w_ctl          = f_fetch(A_PC_NEXT);
        w_ctl.rf_sel   = RF_MEM;
        w_ctl.rf_write = 1'b1;
      end
      S_MEM_ST: w_ctl = f_fetch(A_PC_NEXT);
      S_HALT:   w_ctl.halted = 1'b1;
      S_EXEC: begin
        if (!w_is_halt) begin
          case (w_opc)
            OP_MV: begin
              w_ctl          = f_fetch(A_PC_NEXT);
              w_ctl.rf_sel   = w_imm ? RF_IMM : RF_RY;
              w_ctl.rf_write = 1'b1;
            end
            OP_ADD, OP_SUB, OP_CMP: begin
              w_ctl           = f_fetch(A_PC_NEXT);
              w_ctl.rf_sel    = RF_ALU;
              w_ctl.rf_write  = (w_opc != OP_CMP);
              w_ctl.n_ld      = 1'b1;
              w_ctl.z_ld      = 1'b1;
              w_ctl.alu_op    = (w_opc != OP_ADD);
              w_ctl.alu_b_sel = ~w_imm;
            end
            OP_MVHI: begin
              w_ctl          = f_fetch(A_PC_NEXT);
              w_ctl.rf_sel   = RF_MVHI;
              w_ctl.rf_write = 1'b1;
            end
            OP_LD: begin
              w_ctl.rd       = 1'b1;
              w_ctl.addr_sel = A_RX;
            end
            OP_ST: begin
              w_ctl.wr       = 1'b1;
              w_ctl.addr_sel = A_RX;
            end
            OP_J:  w_ctl = f_jump(w_imm);
            OP_JZ: w_ctl = i_alu_z ? f_jump(w_imm) : f_fetch(A_PC_NEXT);
            OP_JN: w_ctl = i_alu_n ? f_jump(w_imm) : f_fetch(A_PC_NEXT);
            OP_CALL: begin
              w_ctl               = f_jump(w_imm);
              w_ctl.rf_write      = 1'b1;
              w_ctl.rf_sel        = RF_PC;
              w_ctl.rf_addr_w_sel = 1'b1;
            end
            default: if (TRAP_ILLEGAL == 0) w_ctl = f_fetch(A_PC_NEXT);
          endcase
        end
      end
      default: w_ctl = '0;
    endcase

    // A stalled access keeps its request and selects but fires no strobe.
    w_out = w_ctl;
    if (w_stall) begin
      w_out.pc_ld    = 1'b0;
      w_out.ir_ld    = 1'b0;
      w_out.rf_write = 1'b0;
      w_out.n_ld     = 1'b0;
      w_out.z_ld     = 1'b0;
    end
    if (!i_reset_n) w_out = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end

  assign w_retire = (w_out.ir_ld && r_state != S_FETCH) ||
                    (r_state == S_EXEC && w_next == S_HALT);

  sat_counter #(.CNT_W(CNT_W)) u_retired (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_retire),
    .o_cnt     (o_retired)
  );

  assign o_mem_rd        = w_out.rd;
  assign o_mem_wr        = w_out.wr;
  assign o_mem_addr_sel  = w_out.addr_sel;
  assign o_pc_sel        = w_out.pc_sel;
  assign o_pc_ld         = w_out.pc_ld;
  assign o_ir_ld         = w_out.ir_ld;
  assign o_rf_sel        = w_out.rf_sel;
  assign o_rf_write      = w_out.rf_write;
  assign o_rf_addr_w_sel = w_out.rf_addr_w_sel;
  assign o_alu_n_ld      = w_out.n_ld;
  assign o_alu_z_ld      = w_out.z_ld;
  assign o_alu_b_sel     = w_out.alu_b_sel;
  assign o_alu_op        = w_out.alu_op;
  assign o_halted        = w_out.halted;
  assign o_illegal       = r_illegal;
endmodule

// File: tb/tb_cpu_control_ws.sv
// Bench for cpu_control_ws: three instances (default, no-trap, 2-bit counter)
// share one stimulus stream; expected control words go through a queue.
module tb_cpu_control_ws;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ir;
  logic       aln, alz, w;

  logic       rd[3], wr[3], pl[3], il[3], rw[3], aw[3], nl[3], zl[3], bs[3], op[3], hl[3], ill[3];
  logic [2:0] as[3], rs[3];
  logic [1:0] ps[3];
  logic [15:0] ret[3];
  logic [18:0] vec[3];

  int n_chk = 0, n_err = 0, n_ret = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CW = (k == 2) ? 2 : 16;
    logic [CW-1:0] r;
    cpu_control_ws #(.WAIT_EN(1), .TRAP_ILLEGAL((k == 1) ? 0 : 1), .CNT_W(CW), .HALT_OPC(4'hF)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_ir(ir), .i_alu_n(aln), .i_alu_z(alz), .i_mem_wait(w),
      .o_mem_rd(rd[k]), .o_mem_wr(wr[k]), .o_mem_addr_sel(as[k]), .o_pc_sel(ps[k]),
      .o_pc_ld(pl[k]), .o_ir_ld(il[k]), .o_rf_sel(rs[k]), .o_rf_write(rw[k]),
      .o_rf_addr_w_sel(aw[k]), .o_alu_n_ld(nl[k]), .o_alu_z_ld(zl[k]), .o_alu_b_sel(bs[k]),
      .o_alu_op(op[k]), .o_halted(hl[k]), .o_illegal(ill[k]), .o_retired(r));
    assign ret[k] = 16'(r);
    assign vec[k] = {rd[k], wr[k], as[k], ps[k], pl[k], il[k], rs[k], rw[k], aw[k],
                     nl[k], zl[k], bs[k], op[k], hl[k]};
  end

  function automatic logic [18:0] mk(input logic r_, input logic w_, input logic [2:0] a,
      input logic [1:0] p, input logic pld, input logic ild, input logic [2:0] s, input logic rfw,
      input logic awl, input logic nz, input logic b, input logic o, input logic h);
    return {r_, w_, a, p, pld, ild, s, rfw, awl, nz, nz, b, o, h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1: drive, queue expectations, compare at negedge, then retired count.
  task automatic cyc(input string tag, input logic [4:0] irv, input logic wv,
                     input logic [18:0] e, input bit rt, input logic [18:0] e1);
    ir = irv; w = wv;
    sb.push_back(e); sb.push_back(e1);
    @(negedge clk);
    chk(tag, vec[0], sb.pop_front());
    chk({tag, "/notrap"}, vec[1], sb.pop_front());
    if (rt) n_ret++;
    @(posedge clk); #1;
    chk({tag, "/ret"}, ret[0], n_ret);
  endtask

  logic [18:0] FET, SEQ, ADD, LDV, STV, HLT;
  int sat_e[6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    FET = mk(1,0,0,1,1,1,0,0,0,0,0,0,0);
    SEQ = mk(1,0,1,1,1,1,0,0,0,0,0,0,0);
    ADD = mk(1,0,1,1,1,1,2,1,0,1,1,0,0);
    LDV = mk(1,0,3,0,0,0,0,0,0,0,0,0,0);
    STV = mk(0,1,3,0,0,0,0,0,0,0,0,0,0);
    HLT = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);
    rst_n = 1'b0; ir = 5'h01; aln = 1'b0; alz = 1'b0; w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", vec[0], 0);
    chk("rst_ret", ret[0], 0);
    chk("rst_ill", ill[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc("fetch",  5'h01, 0, FET, 0, FET);
    cyc("add",    5'h01, 0, ADD, 1, ADD);
    for (int i = 0; i < 3; i++) cyc("ld_wait", 5'h04, 1, LDV, 0, LDV);
    cyc("ld",     5'h04, 0, LDV, 0, LDV);
    cyc("mem_ld", 5'h05, 0, mk(1,0,1,1,1,1,4,1,0,0,0,0,0), 1, mk(1,0,1,1,1,1,4,1,0,0,0,0,0));
    cyc("st_wait",5'h05, 1, STV, 0, STV);
    cyc("st",     5'h05, 0, STV, 0, STV);
    cyc("mem_st", 5'h09, 0, SEQ, 1, SEQ);
    cyc("jz_nt",  5'h09, 0, SEQ, 1, SEQ);
    alz = 1'b1;
    cyc("jz_t",   5'h19, 0, mk(1,0,4,2,1,1,0,0,0,0,0,0,0), 1, mk(1,0,4,2,1,1,0,0,0,0,0,0,0));
    alz = 1'b0; aln = 1'b1;
    cyc("jn_t",   5'h0A, 0, mk(1,0,2,0,1,1,0,0,0,0,0,0,0), 1, mk(1,0,2,0,1,1,0,0,0,0,0,0,0));
    aln = 1'b0;
    cyc("jn_nt",  5'h0A, 0, SEQ, 1, SEQ);
    cyc("call",   5'h1C, 0, mk(1,0,4,2,1,1,3,1,1,0,0,0,0), 1, mk(1,0,4,2,1,1,3,1,1,0,0,0,0));
    cyc("callr",  5'h0C, 0, mk(1,0,2,0,1,1,3,1,1,0,0,0,0), 1, mk(1,0,2,0,1,1,3,1,1,0,0,0,0));
    cyc("cmpi",   5'h13, 0, mk(1,0,1,1,1,1,2,0,0,1,0,1,0), 1, mk(1,0,1,1,1,1,2,0,0,1,0,1,0));
    cyc("sub",    5'h02, 0, mk(1,0,1,1,1,1,2,1,0,1,1,1,0), 1, mk(1,0,1,1,1,1,2,1,0,1,1,1,0));
    cyc("mvi",    5'h10, 0, mk(1,0,1,1,1,1,0,1,0,0,0,0,0), 1, mk(1,0,1,1,1,1,0,1,0,0,0,0,0));
    cyc("mv",     5'h00, 0, mk(1,0,1,1,1,1,6,1,0,0,0,0,0), 1, mk(1,0,1,1,1,1,6,1,0,0,0,0,0));
    cyc("mvhi",   5'h06, 0, mk(1,0,1,1,1,1,1,1,0,0,0,0,0), 1, mk(1,0,1,1,1,1,1,1,0,0,0,0,0));
    cyc("add_wait",5'h01, 1, mk(1,0,1,1,0,0,2,0,0,0,1,0,0), 0, mk(1,0,1,1,0,0,2,0,0,0,1,0,0));
    cyc("add_go", 5'h01, 0, ADD, 1, ADD);
    cyc("illegal",5'h07, 0, 19'h0, 1, SEQ);
    cyc("halted", 5'h0F, 0, HLT, 0, 19'h0);
    cyc("halted2",5'h0F, 0, HLT, 0, HLT);
    chk("ill_trap",   ill[0], 1);
    chk("ill_notrap", ill[1], 0);
    chk("ret_notrap", ret[1], n_ret + 1);

    rst_n = 1'b0; ir = 5'h01; w = 1'b0;
    @(negedge clk);
    chk("rst2_vec", vec[0], 0);
    chk("rst2_ill", ill[0], 0);
    chk("rst2_ret", ret[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d", i), ret[2], sat_e[i]);
    end
    ir = 5'h04; w = 1'b1;
    @(negedge clk);
    chk("ld_stall", vec[0], LDV);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vec",  vec[0], 0);
    chk("rst_mid_vec2", vec[2], 0);
    chk("rst_mid_ret",  ret[0], 0);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
